// File: rtl/branch_resolve_unit.sv
// Branch resolution: compares resolved outcome to prediction, drives flush/redirect,
// pulses predictor updates and queues ROB/CDB writebacks in a small FIFO.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fu_valid,
    output logic             fu_ready,
    input  logic             fu_ctrl,
    input  logic [XLEN-1:0]  fu_result,
    input  logic [XLEN-1:0]  fu_link_reg,
    input  logic             fu_taken,
    input  logic             fu_link,
    input  logic [XLEN-1:0]  fu_pc,
    input  logic [TAG_W-1:0] fu_tag,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic             bpu_upd_valid,
    output logic [XLEN-1:0]  bpu_upd_pc,
    output logic             bpu_upd_taken,
    output logic [XLEN-1:0]  bpu_upd_target,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_we,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_mispred
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

    state_t state, state_next;

    logic [TAG_W-1:0] fifo_tag     [DEPTH];
    logic             fifo_we      [DEPTH];
    logic [XLEN-1:0]  fifo_data    [DEPTH];
    logic             fifo_mispred [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic accept, mispred, push, pop;
    logic [XLEN-1:0] correct_pc;

    assign fu_ready   = (state == IDLE) && (count < CNT_W'(DEPTH));
    assign accept     = fu_valid && fu_ready;
    assign mispred    = fu_ctrl && ((fu_taken != pred_taken) ||
                                    (fu_taken && (fu_result != pred_target)));
    assign correct_pc = fu_taken ? fu_result : fu_pc + XLEN'(4);
    assign push       = accept;
    assign wb_valid   = (count != '0);
    assign pop        = wb_valid && wb_ready;

    assign redirect_valid = (state == REDIRECT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && mispred) state_next = REDIRECT;
            REDIRECT: if (redirect_ready)    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            bpu_upd_valid  <= 1'b0;
            bpu_upd_pc     <= '0;
            bpu_upd_taken  <= 1'b0;
            bpu_upd_target <= '0;
        end else begin
            state         <= state_next;
            flush         <= accept && mispred;
            bpu_upd_valid <= accept && fu_ctrl;
            if (accept && mispred) begin
                redirect_pc <= correct_pc;
            end
            if (accept && fu_ctrl) begin
                bpu_upd_pc     <= fu_pc;
                bpu_upd_taken  <= fu_taken;
                bpu_upd_target <= fu_result;
            end
        end
    end

    // Storage is not reset: resetting the pointers and count discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr]     <= fu_tag;
            fifo_we[wr_ptr]      <= fu_link || !fu_ctrl;
            fifo_data[wr_ptr]    <= fu_link ? fu_link_reg : fu_result;
            fifo_mispred[wr_ptr] <= mispred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign wb_tag     = fifo_tag[rd_ptr];
    assign wb_we      = fifo_we[rd_ptr];
    assign wb_data    = fifo_data[rd_ptr];
    assign wb_mispred = fifo_mispred[rd_ptr];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fu_valid;
    logic             fu_ready;
    logic             fu_ctrl;
    logic [XLEN-1:0]  fu_result;
    logic [XLEN-1:0]  fu_link_reg;
    logic             fu_taken;
    logic             fu_link;
    logic [XLEN-1:0]  fu_pc;
    logic [TAG_W-1:0] fu_tag;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             bpu_upd_valid;
    logic [XLEN-1:0]  bpu_upd_pc;
    logic             bpu_upd_taken;
    logic [XLEN-1:0]  bpu_upd_target;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_we;
    logic [XLEN-1:0]  wb_data;
    logic             wb_mispred;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_ctrl(fu_ctrl), .fu_result(fu_result), .fu_link_reg(fu_link_reg),
        .fu_taken(fu_taken), .fu_link(fu_link), .fu_pc(fu_pc), .fu_tag(fu_tag),
        .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .bpu_upd_valid(bpu_upd_valid),
        .bpu_upd_pc(bpu_upd_pc), .bpu_upd_taken(bpu_upd_taken),
        .bpu_upd_target(bpu_upd_target), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_tag(wb_tag), .wb_we(wb_we), .wb_data(wb_data), .wb_mispred(wb_mispred)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ctrl, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] result, input logic taken,
                         input logic ptaken, input logic [XLEN-1:0] ptarget,
                         input logic link, input logic [XLEN-1:0] link_reg,
                         input logic [TAG_W-1:0] tag);
        fu_valid    = 1'b1;
        fu_ctrl     = ctrl;
        fu_pc       = pc;
        fu_result   = result;
        fu_taken    = taken;
        pred_taken  = ptaken;
        pred_target = ptarget;
        fu_link     = link;
        fu_link_reg = link_reg;
        fu_tag      = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got %0b want 0", flush); else passed++;
        total++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect_valid got %0b want 0", redirect_valid); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); else passed++;
        total++; if (bpu_upd_valid !== 1'b0 || bpu_upd_pc !== 32'h0 || bpu_upd_taken !== 1'b0 || bpu_upd_target !== 32'h0)
            $display("FAIL reset_bpu got v=%0b pc=%h t=%0b tgt=%h want all 0", bpu_upd_valid, bpu_upd_pc, bpu_upd_taken, bpu_upd_target); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %0b want 0", wb_valid); else passed++;
        total++; if (fu_ready !== 1'b1) $display("FAIL reset_fu_ready got %0b want 1", fu_ready); else passed++;
    endtask

    task automatic test_correct_taken();
        drive(1'b1, 32'h3000_0000, 32'h3000_000F, 1'b1, 1'b1, 32'h3000_000F, 1'b0, 32'h0, 6'd5);
        tick();
        fu_valid = 1'b0;
        total++; if (bpu_upd_valid !== 1'b1) $display("FAIL ct_bpu_valid got %0b want 1", bpu_upd_valid); else passed++;
        total++; if (bpu_upd_pc !== 32'h3000_0000 || bpu_upd_taken !== 1'b1 || bpu_upd_target !== 32'h3000_000F)
            $display("FAIL ct_bpu_fields got pc=%h t=%0b tgt=%h want 30000000/1/3000000f", bpu_upd_pc, bpu_upd_taken, bpu_upd_target); else passed++;
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL ct_no_flush got flush=%0b rv=%0b want 0/0", flush, redirect_valid); else passed++;
        total++; if (wb_valid !== 1'b1 || wb_tag !== 6'd5 || wb_we !== 1'b0 || wb_mispred !== 1'b0 || wb_data !== 32'h3000_000F)
            $display("FAIL ct_wb got v=%0b tag=%0d we=%0b mp=%0b data=%h want 1/5/0/0/3000000f", wb_valid, wb_tag, wb_we, wb_mispred, wb_data); else passed++;
        tick();
        total++; if (bpu_upd_valid !== 1'b0) $display("FAIL ct_bpu_pulse got %0b want 0", bpu_upd_valid); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL ct_wb_drained got %0b want 0", wb_valid); else passed++;
    endtask

    task automatic test_dir_mispred();
        redirect_ready = 1'b0;
        drive(1'b1, 32'h3000_000F, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 6'd6);
        tick();
        // Keep offering a new op while redirecting; it must not be taken.
        fu_tag = 6'd9;
        total++; if (flush !== 1'b1) $display("FAIL dm_flush got %0b want 1", flush); else passed++;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000_0013)
            $display("FAIL dm_redirect got rv=%0b pc=%h want 1/30000013", redirect_valid, redirect_pc); else passed++;
        total++; if (fu_ready !== 1'b0) $display("FAIL dm_fu_ready got %0b want 0", fu_ready); else passed++;
        total++; if (wb_tag !== 6'd6 || wb_mispred !== 1'b1 || bpu_upd_taken !== 1'b0)
            $display("FAIL dm_wb got tag=%0d mp=%0b bpu_t=%0b want 6/1/0", wb_tag, wb_mispred, bpu_upd_taken); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h3000_0013 || fu_ready !== 1'b0 || wb_valid !== 1'b0)
                $display("FAIL dm_hold%0d got flush=%0b rv=%0b pc=%h rdy=%0b wbv=%0b want 0/1/30000013/0/0",
                         i, flush, redirect_valid, redirect_pc, fu_ready, wb_valid); else passed++;
        end
        fu_valid = 1'b0;
        redirect_ready = 1'b1;
        tick();
        total++; if (redirect_valid !== 1'b0 || fu_ready !== 1'b1)
            $display("FAIL dm_release got rv=%0b rdy=%0b want 0/1", redirect_valid, fu_ready); else passed++;
    endtask

    task automatic test_target_mispred();
        redirect_ready = 1'b1;
        drive(1'b1, 32'h3000_000F, 32'h0000_000F, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h3000_0013, 6'd7);
        tick();
        fu_valid = 1'b0;
        total++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_000F)
            $display("FAIL tm_redirect got flush=%0b rv=%0b pc=%h want 1/1/0000000f", flush, redirect_valid, redirect_pc); else passed++;
        total++; if (wb_tag !== 6'd7 || wb_we !== 1'b1 || wb_data !== 32'h3000_0013 || wb_mispred !== 1'b1)
            $display("FAIL tm_wb got tag=%0d we=%0b data=%h mp=%0b want 7/1/30000013/1", wb_tag, wb_we, wb_data, wb_mispred); else passed++;
        total++; if (bpu_upd_target !== 32'h0000_000F) $display("FAIL tm_bpu_target got %h want 0000000f", bpu_upd_target); else passed++;
        tick();
        total++; if (redirect_valid !== 1'b0 || fu_ready !== 1'b1 || flush !== 1'b0)
            $display("FAIL tm_single_cycle got rv=%0b rdy=%0b flush=%0b want 0/1/0", redirect_valid, fu_ready, flush); else passed++;
    endtask

    task automatic test_pc_wrap();
        redirect_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 6'd8);
        tick();
        fu_valid = 1'b0;
        total++; if (redirect_pc !== 32'h0 || flush !== 1'b1) $display("FAIL wrap_pc got pc=%h flush=%0b want 00000000/1", redirect_pc, flush); else passed++;
        tick();
    endtask

    task automatic test_fifo_full();
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'h200, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, 6'(10 + i));
            tick();
        end
        fu_valid = 1'b0;
        total++; if (fu_ready !== 1'b0 || wb_tag !== 6'd10) $display("FAIL full_ready got rdy=%0b head=%0d want 0/10", fu_ready, wb_tag); else passed++;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        total++; if (fu_ready !== 1'b1 || wb_tag !== 6'd11) $display("FAIL full_pop got rdy=%0b head=%0d want 1/11", fu_ready, wb_tag); else passed++;
        drive(1'b1, 32'h110, 32'h200, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, 6'd14);
        tick();
        fu_valid = 1'b0;
        total++; if (fu_ready !== 1'b0) $display("FAIL refill_full got %0b want 0", fu_ready); else passed++;
        wb_ready = 1'b1;
        for (int t = 11; t <= 14; t++) begin
            total++; if (wb_valid !== 1'b1 || wb_tag !== 6'(t)) $display("FAIL drain_tag got v=%0b tag=%0d want 1/%0d", wb_valid, wb_tag, t); else passed++;
            tick();
        end
        total++; if (wb_valid !== 1'b0) $display("FAIL drain_empty got %0b want 0", wb_valid); else passed++;
        for (int t = 15; t <= 19; t++) begin
            drive(1'b1, 32'h120, 32'h200, 1'b0, 1'b0, 32'h200, 1'b0, 32'h0, 6'(t));
            tick();
            total++; if (wb_valid !== 1'b1 || wb_tag !== 6'(t)) $display("FAIL stream_tag got v=%0b tag=%0d want 1/%0d", wb_valid, wb_tag, t); else passed++;
        end
        fu_valid = 1'b0;
        tick();
        total++; if (wb_valid !== 1'b0) $display("FAIL stream_empty got %0b want 0", wb_valid); else passed++;
    endtask

    task automatic test_auipc();
        drive(1'b0, 32'h3000_0000, 32'h3000_0100, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 6'd20);
        tick();
        fu_valid = 1'b0;
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || bpu_upd_valid !== 1'b0)
            $display("FAIL auipc_ctrl got flush=%0b rv=%0b bpu=%0b want 0/0/0", flush, redirect_valid, bpu_upd_valid); else passed++;
        total++; if (wb_tag !== 6'd20 || wb_we !== 1'b1 || wb_data !== 32'h3000_0100 || wb_mispred !== 1'b0)
            $display("FAIL auipc_wb got tag=%0d we=%0b data=%h mp=%0b want 20/1/30000100/0", wb_tag, wb_we, wb_data, wb_mispred); else passed++;
        tick();
    endtask

    task automatic test_reset_in_redirect();
        wb_ready = 1'b0;
        redirect_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0000_0500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'd21);
        tick();
        fu_tag = 6'd22;
        tick();
        drive(1'b1, 32'h0000_0040, 32'h0000_0080, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'd23);
        tick();
        fu_valid = 1'b0;
        total++; if (redirect_valid !== 1'b1 || wb_valid !== 1'b1 || wb_tag !== 6'd21 || redirect_pc !== 32'h80)
            $display("FAIL rr_setup got rv=%0b wbv=%0b head=%0d pc=%h want 1/1/21/00000080", redirect_valid, wb_valid, wb_tag, redirect_pc); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (redirect_valid !== 1'b0 || wb_valid !== 1'b0 || fu_ready !== 1'b1)
            $display("FAIL rr_state got rv=%0b wbv=%0b rdy=%0b want 0/0/1", redirect_valid, wb_valid, fu_ready); else passed++;
        total++; if (flush !== 1'b0 || redirect_pc !== 32'h0 || bpu_upd_valid !== 1'b0 || bpu_upd_pc !== 32'h0)
            $display("FAIL rr_outputs got flush=%0b pc=%h bpu=%0b bpc=%h want 0/0/0/0", flush, redirect_pc, bpu_upd_valid, bpu_upd_pc); else passed++;
        wb_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        fu_valid = 1'b0; fu_ctrl = 1'b0; fu_result = '0; fu_link_reg = '0;
        fu_taken = 1'b0; fu_link = 1'b0; fu_pc = '0; fu_tag = '0;
        pred_taken = 1'b0; pred_target = '0;
        redirect_ready = 1'b0; wb_ready = 1'b1;
        #2;
        test_reset();
        test_correct_taken();
        test_dir_mispred();
        test_target_mispred();
        test_pc_wrap();
        test_fifo_full();
        test_auipc();
        test_reset_in_redirect();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
